// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction memory arbiter: default sizing,
// index-width helper, address array types and the round-robin pointer step.
package imem_arb_pkg;

  localparam int DEF_N_REQ             = 4;
  localparam int DEF_MEMORY_WIDTH      = 16;
  localparam int DEF_MEMORY_ADDR_WIDTH = 11;

  // Width of a requester index; never below one bit so the pointer is a real signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_IDX_WIDTH = idx_width(DEF_N_REQ);

  typedef logic [DEF_MEMORY_ADDR_WIDTH-1:0] addr_t;
  typedef addr_t addr_array_t [DEF_N_REQ];

  // Round-robin pointer step: one past the last winner, wrapping n-1 -> 0.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin priority selector: picks the first asserted
// request at or after rr_ptr, wrapping around the request vector.
module rr_priority_select
  import imem_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    winner,
  output logic             any_grant
);

  // Scan from rr_ptr upward modulo N_REQ; the first hit wins.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the scan so no path leaves
    // a value unassigned, which would infer a latch.
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        winner     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/instruction_memory_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory (1-cycle
// read latency) among N_REQ basic_block engines. One address per cycle,
// response data broadcast with a per-engine registered resp_valid.
// Optional feature: define IMEM_ARB_COALESCE_EN to also grant every valid
// requester whose address matches the primary winner's in the same cycle.
module instruction_memory_arbiter
  import imem_arb_pkg::*;
#(
  parameter int N_REQ             = DEF_N_REQ,
  parameter int MEMORY_WIDTH      = DEF_MEMORY_WIDTH,
  parameter int MEMORY_ADDR_WIDTH = DEF_MEMORY_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]                   req_ready,
  output logic [MEMORY_WIDTH-1:0]            req_data,
  output logic [N_REQ-1:0]                   resp_valid,
  output logic                               mem_en,
  output logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr,
  input  logic [MEMORY_WIDTH-1:0]            mem_rdata
);

  localparam int IW = idx_width(N_REQ);

  logic [IW-1:0]                rr_ptr;
  logic [N_REQ-1:0]             live_req;
  logic [N_REQ-1:0]             primary_grant;
  logic [N_REQ-1:0]             resp_q;
  logic [IW-1:0]                winner;
  logic                         any_grant;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_arr [N_REQ];

  // Requests are ignored while reset is held, so grants and the memory port stay quiet.
  assign live_req = reset ? req_valid : '0;

  for (genvar i = 0; i < N_REQ; i++) begin : g_addr
    assign addr_arr[i] = req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  end

  rr_priority_select #(.N_REQ(N_REQ)) u_select (
    .req       (live_req),
    .rr_ptr    (rr_ptr),
    .grant     (primary_grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  assign mem_en   = any_grant;
  assign mem_addr = any_grant ? addr_arr[winner] : '0;
  assign req_data = mem_rdata;

`ifdef IMEM_ARB_COALESCE_EN
  // Piggy-back every live requester fetching the same word as the primary winner.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (any_grant && live_req[i] && (addr_arr[i] == mem_addr)) req_ready[i] = 1'b1;
    end
  end
`else
  assign req_ready = primary_grant;
`endif

  // Pointer advances past the primary winner; resp_valid tracks last cycle's grants.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
      resp_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of statement order.
      resp_q <= req_ready;
      if (any_grant) rr_ptr <= IW'(rr_next(int'(winner), N_REQ));
    end
  end

  // A read in flight when reset arrives is discarded rather than reported.
  assign resp_valid = resp_q & {N_REQ{reset}};

endmodule

// File: tb/tb_instruction_memory_arbiter.sv
// Self-checking bench for instruction_memory_arbiter (N_REQ=4): directed
// vector table with a response scoreboard, then a randomized fairness run.
module tb_instruction_memory_arbiter;
  import imem_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] req_data;
  logic [N-1:0]  resp_valid;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_memory_arbiter #(
    .N_REQ(N), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  // Instruction memory contents as a pure function of address.
  function automatic logic [DW-1:0] mem_fn(input addr_t a);
    return (a == 11'h0CC) ? 16'h100F : (16'h5000 | {5'd0, a});
  endfunction

  // Single-port memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_fn(mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    addr_array_t a;
    logic [3:0]  exp_ready;
    addr_t       exp_addr;
    logic [REQ_IDX_WIDTH-1:0] exp_rr;
  } vec_t;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] data;
  } resp_t;

  vec_t  tbl[$];
  resp_t sb[$];

  function automatic vec_t mk(input logic r, input logic [3:0] v,
                              input addr_t a0, input addr_t a1, input addr_t a2, input addr_t a3,
                              input logic [3:0] rdy, input addr_t ea, input logic [1:0] rr);
    vec_t t;
    t.rst_n = r; t.valid = v;
    t.a[0] = a0; t.a[1] = a1; t.a[2] = a2; t.a[3] = a3;
    t.exp_ready = rdy; t.exp_addr = ea; t.exp_rr = rr;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    resp_t e;
    @(negedge clk);
    reset     = t.rst_n;
    req_valid = t.valid;
    req_addr  = {t.a[3], t.a[2], t.a[1], t.a[0]};
    #1;
    e.mask = 4'b0000; e.data = 16'h0000;
    if (sb.size() > 0) e = sb.pop_front();
    if (!t.rst_n) e.mask = 4'b0000;
    check("resp_valid", 32'(resp_valid), 32'(e.mask));
    if (e.mask != 4'b0000) check("req_data", 32'(req_data), 32'(e.data));
    check("req_ready", 32'(req_ready), 32'(t.exp_ready));
    check("mem_en", 32'(mem_en), 32'(t.exp_ready != 4'b0000));
    check("mem_addr", 32'(mem_addr), 32'(t.exp_addr));
    check("rr_ptr", 32'(dut.rr_ptr), 32'(t.exp_rr));
    e.mask = t.rst_n ? t.exp_ready : 4'b0000;
    e.data = mem_fn(t.exp_addr);
    sb.push_back(e);
  endtask

  initial begin
    logic [N-1:0] pend;
    int           waited [N];

    reset = 1'b0; req_valid = '0; req_addr = '0;
    repeat (2) @(posedge clk);

    //           rst valid  a0      a1      a2      a3      ready   addr    rr
    tbl.push_back(mk(0, 4'b0000, 11'h0,   11'h0,  11'h0,  11'h0,  4'b0000, 11'h0,   2'd0));
    tbl.push_back(mk(1, 4'b0000, 11'h0,   11'h0,  11'h0,  11'h0,  4'b0000, 11'h0,   2'd0));
    tbl.push_back(mk(1, 4'b0001, 11'h0CC, 11'h0,  11'h0,  11'h0,  4'b0001, 11'h0CC, 2'd0));
    tbl.push_back(mk(1, 4'b0000, 11'h0,   11'h0,  11'h0,  11'h0,  4'b0000, 11'h0,   2'd1));
    tbl.push_back(mk(0, 4'b1111, 11'h10,  11'h11, 11'h12, 11'h13, 4'b0000, 11'h0,   2'd1));
    tbl.push_back(mk(1, 4'b1111, 11'h10,  11'h11, 11'h12, 11'h13, 4'b0001, 11'h10,  2'd0));
    tbl.push_back(mk(1, 4'b1111, 11'h10,  11'h11, 11'h12, 11'h13, 4'b0010, 11'h11,  2'd1));
    tbl.push_back(mk(1, 4'b1111, 11'h10,  11'h11, 11'h12, 11'h13, 4'b0100, 11'h12,  2'd2));
    tbl.push_back(mk(1, 4'b1111, 11'h10,  11'h11, 11'h12, 11'h13, 4'b1000, 11'h13,  2'd3));
    tbl.push_back(mk(1, 4'b1111, 11'h10,  11'h11, 11'h12, 11'h13, 4'b0001, 11'h10,  2'd0));
    tbl.push_back(mk(1, 4'b0100, 11'h0,   11'h0,  11'h22, 11'h0,  4'b0100, 11'h22,  2'd1));
    tbl.push_back(mk(1, 4'b0101, 11'h0A0, 11'h0,  11'h22, 11'h0,  4'b0001, 11'h0A0, 2'd3));
    tbl.push_back(mk(1, 4'b0100, 11'h0A0, 11'h0,  11'h22, 11'h0,  4'b0100, 11'h22,  2'd1));
    tbl.push_back(mk(1, 4'b0010, 11'h0,   11'h31, 11'h0,  11'h0,  4'b0010, 11'h31,  2'd3));
    tbl.push_back(mk(0, 4'b0010, 11'h0,   11'h31, 11'h0,  11'h0,  4'b0000, 11'h0,   2'd2));
    tbl.push_back(mk(1, 4'b0000, 11'h0,   11'h0,  11'h0,  11'h0,  4'b0000, 11'h0,   2'd0));
`ifdef IMEM_ARB_COALESCE_EN
    tbl.push_back(mk(1, 4'b0101, 11'h0CD, 11'h0,  11'h0CD, 11'h0, 4'b0101, 11'h0CD, 2'd0));
    tbl.push_back(mk(1, 4'b0000, 11'h0,   11'h0,  11'h0,  11'h0,  4'b0000, 11'h0,   2'd1));
    tbl.push_back(mk(1, 4'b0000, 11'h0,   11'h0,  11'h0,  11'h0,  4'b0000, 11'h0,   2'd1));
`else
    tbl.push_back(mk(1, 4'b0101, 11'h0CD, 11'h0,  11'h0CD, 11'h0, 4'b0001, 11'h0CD, 2'd0));
    tbl.push_back(mk(1, 4'b0100, 11'h0,   11'h0,  11'h0CD, 11'h0, 4'b0100, 11'h0CD, 2'd1));
    tbl.push_back(mk(1, 4'b0000, 11'h0,   11'h0,  11'h0,  11'h0,  4'b0000, 11'h0,   2'd3));
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Randomized fairness run: pending requests are held until granted and
    // must be served within N grant cycles; distinct addresses per engine.
    pend = '0;
    for (int i = 0; i < N; i++) waited[i] = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) pend[i] = ($urandom_range(0, 3) != 0);
      end
      reset     = 1'b1;
      req_valid = pend;
      req_addr  = {11'h43, 11'h42, 11'h41, 11'h40};
      #1;
      check("grant_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      check("grant_subset", 32'(req_ready & ~pend), 32'd0);
      check("grant_when_pending", 32'(req_ready != 4'b0000), 32'(pend != 4'b0000));
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          waited[i]++;
          if (req_ready[i]) begin
            check("starvation_bound", 32'(waited[i] <= N), 32'd1);
            waited[i] = 0;
            pend[i]   = 1'b0;
          end else if (waited[i] > N) begin
            check("starvation_bound", 32'(waited[i] <= N), 32'd1);
            waited[i] = 0;
          end
        end
      end
    end

    @(negedge clk);
    req_valid = '0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
